// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage constants, state encoding and entry type
package fetch_pkg;

    localparam int FETCH_ADDR_W     = 16;
    localparam int FETCH_INSTR_W    = 16;
    localparam int FETCH_FIFO_DEPTH = 2;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic int fetch_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetched {pc, instr} entries with flush
import fetch_pkg::*;

module fetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = fetch_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding imem read, FIFO to decode
// Defining FETCH_BYPASS_EN forwards an acked word straight to decode when the FIFO is empty.
import fetch_pkg::*;

module fetch_unit #(
    parameter int ADDR_W     = FETCH_ADDR_W,
    parameter int INSTR_W    = FETCH_INSTR_W,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               should_jump,
    output logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CNT_W = fetch_cnt_w(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            fifo_wdata;
    entry_t            fifo_rdata;
    logic              fifo_valid;
    logic              ack_live;
    logic              bypass;

    // Only an ack in WAIT completes a useful fetch; acks in DISCARD belong to a flushed path.
    assign ack_live = (state_q == ST_WAIT) & imem_ack;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty & ack_live & ~should_jump & instr_ready;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!should_jump && !fifo_full) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    fifo_push = ~should_jump & ~bypass;
                end else if (should_jump) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign fifo_wdata = '{pc: addr_q, instr: imem_rdata};
    assign fifo_valid = (fifo_count != '0);
    assign fifo_pop   = fifo_valid & instr_ready;

    fetch_fifo #(
        .DATA_W ($bits(entry_t)),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (should_jump),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = fifo_valid | bypass;
    assign instr       = bypass ? imem_rdata : fifo_rdata.instr;
    assign instr_pc    = bypass ? addr_q : fifo_rdata.pc;
    // Held high during reset so the PC generator cannot run ahead of an idle fetch unit.
    assign stall       = ~rst_n | ~(should_jump | ack_live);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with imem and PC generator models
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW    = FETCH_ADDR_W;
    localparam int IW    = FETCH_INSTR_W;
    localparam int DEPTH = FETCH_FIFO_DEPTH;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          should_jump = 1'b0;
    logic          stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;

    int total = 0;
    int bad   = 0;

    int            fixed_lat = 1;
    int            lat;
    int            age;
    bit            stale;
    bit            req_prev;
    bit            ack_prev;
    logic [AW-1:0] addr_prev;
    logic [AW-1:0] jump_tgt;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] last_del_pc;
    int            delivered;

    typedef struct {
        bit            rdy;
        bit            jmp;
        logic [AW-1:0] tgt;
        bit            exp_stall;
        bit            exp_v_nb;
        bit            exp_v_b;
        logic [AW-1:0] exp_ipc;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W     (AW),
        .INSTR_W    (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .should_jump (should_jump),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
        return IW'(32'hA000 ^ 32'(a));
    endfunction

    function automatic int next_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        should_jump = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        jump_tgt    = '0;
        pc          = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        age       = 0;
        stale     = 1'b0;
        req_prev  = 1'b0;
        ack_prev  = 1'b0;
        addr_prev = '0;
        exp_pc    = '0;
        delivered = 0;
        lat       = next_lat();
    endtask

    // Called just after a rising edge: apply inputs, let logic settle, check against the model.
    task automatic drive_sample(input bit jmp, input logic [AW-1:0] tgt, input bit rdy);
        should_jump = jmp;
        jump_tgt    = tgt;
        instr_ready = rdy;
        imem_ack    = imem_req && (age >= lat);
        imem_rdata  = imem_ack ? word_of(imem_addr) : IW'($urandom);
        #2;
        check("stall", stall, !(jmp || (imem_ack && !stale)));
        if (req_prev && !ack_prev)
            check("req_hold", {imem_req, imem_addr}, {1'b1, addr_prev});
        if (instr_valid && rdy && !jmp) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, word_of(exp_pc));
            last_del_pc = instr_pc;
            exp_pc      = exp_pc + 1'b1;
            delivered++;
        end
    endtask

    // PC generator and memory bookkeeping, then move to the next cycle.
    task automatic advance();
        logic [AW-1:0] pc_n;
        pc_n = stall ? pc : (should_jump ? jump_tgt : pc + 1'b1);
        if (should_jump) exp_pc = jump_tgt;
        if (imem_req && imem_ack) begin
            stale = 1'b0;
            age   = 0;
            lat   = next_lat();
        end else if (imem_req) begin
            age++;
            if (should_jump) stale = 1'b1;
        end
        req_prev  = imem_req;
        ack_prev  = imem_ack;
        addr_prev = imem_addr;
        @(posedge clk);
        #1;
        pc = pc_n;
    endtask

    task automatic run_until_delivery(input int budget);
        int d0;
        d0 = delivered;
        for (int i = 0; i < budget && delivered == d0; i++) begin
            drive_sample(1'b0, '0, 1'b1);
            advance();
        end
        check("delivery_timeout", delivered > d0, 1);
    endtask

    initial begin
        int d0;
        int rand_start;

        // straight line with 1-cycle ack latency, then a jump while a read is outstanding
        vecs[0]  = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[2]  = '{1, 0, 16'h0000, 0, 0, 1, 16'h0000};
        vecs[3]  = '{1, 0, 16'h0000, 1, 1, 0, 16'h0000};
        vecs[4]  = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[5]  = '{1, 0, 16'h0000, 0, 0, 1, 16'h0001};
        vecs[6]  = '{1, 0, 16'h0000, 1, 1, 0, 16'h0001};
        vecs[7]  = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[8]  = '{1, 0, 16'h0000, 0, 0, 1, 16'h0002};
        vecs[9]  = '{1, 0, 16'h0000, 1, 1, 0, 16'h0002};
        vecs[10] = '{1, 1, 16'h0040, 0, 0, 0, 16'h0000};
        vecs[11] = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[12] = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[13] = '{1, 0, 16'h0000, 1, 0, 0, 16'h0000};
        vecs[14] = '{1, 0, 16'h0000, 0, 0, 1, 16'h0040};
        vecs[15] = '{1, 0, 16'h0000, 1, 1, 0, 16'h0040};

        // reset asserted mid-WAIT
        fixed_lat = 100;
        do_reset();
        drive_sample(1'b0, '0, 1'b1);
        advance();
        drive_sample(1'b0, '0, 1'b1);
        check("t1_req_up", imem_req, 1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_req", imem_req, 0);
        check("t1_rst_valid", instr_valid, 0);
        check("t1_rst_stall", stall, 1);
        check("t1_rst_addr", imem_addr, 0);
        check("t1_rst_instr", {instr, instr_pc}, 0);

        // table-driven: straight line and jump into DISCARD
        fixed_lat = 1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_sample(vecs[i].jmp, vecs[i].tgt, vecs[i].rdy);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_valid", i), instr_valid, BYP ? vecs[i].exp_v_b : vecs[i].exp_v_nb);
            if (BYP ? vecs[i].exp_v_b : vecs[i].exp_v_nb)
                check($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].exp_ipc);
            advance();
        end

        // backpressure: FIFO fills, fetching stops, then drains in order
        fixed_lat = 1;
        do_reset();
        repeat (20) begin
            drive_sample(1'b0, '0, 1'b0);
            advance();
        end
        drive_sample(1'b0, '0, 1'b0);
        check("bp_no_req", imem_req, 0);
        check("bp_stall", stall, 1);
        check("bp_valid", instr_valid, 1);
        check("bp_head", instr_pc, 0);
        advance();
        for (int i = 0; i < 40 && delivered < DEPTH + 1; i++) begin
            drive_sample(1'b0, '0, 1'b1);
            advance();
        end
        check("bp_drain", delivered, DEPTH + 1);

        // jump while WAIT with a buffered entry; stale ack arrives in DISCARD
        fixed_lat = 1;
        do_reset();
        repeat (2) begin
            drive_sample(1'b0, '0, 1'b0);
            advance();
        end
        fixed_lat = 100;
        repeat (3) begin
            drive_sample(1'b0, '0, 1'b0);
            advance();
        end
        drive_sample(1'b1, 16'd128, 1'b0);
        check("t4_pre_valid", instr_valid, 1);
        advance();
        fixed_lat = 1;
        lat = 0;
        drive_sample(1'b0, '0, 1'b0);
        check("t4_flushed", instr_valid, 0);
        check("t4_discard_req", imem_req, 1);
        advance();
        drive_sample(1'b0, '0, 1'b0);
        check("t4_idle_req", imem_req, 0);
        advance();
        drive_sample(1'b0, '0, 1'b0);
        check("t4_new_req", {imem_req, imem_addr}, {1'b1, 16'd128});
        advance();
        run_until_delivery(20);
        check("t4_first_pc", last_del_pc, 128);

        // jump coincident with ack: word dropped
        fixed_lat = 1;
        do_reset();
        repeat (2) begin
            drive_sample(1'b0, '0, 1'b1);
            advance();
        end
        drive_sample(1'b1, 16'd64, 1'b1);
        check("t5_stall", stall, 0);
        check("t5_no_bypass", instr_valid, 0);
        advance();
        drive_sample(1'b0, '0, 1'b1);
        check("t5_dropped", instr_valid, 0);
        advance();
        run_until_delivery(20);
        check("t5_first_pc", last_del_pc, 64);

        // randomized traffic against the reference model
        fixed_lat = -1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_sample($urandom_range(0, 19) == 0, AW'($urandom), $urandom_range(0, 9) < 7);
            advance();
        end
        rand_start = delivered;
        check("rand_activity", rand_start > 100, 1);
        d0 = delivered;
        for (int i = 0; i < 300 && delivered < d0 + 6; i++) begin
            drive_sample(1'b0, '0, 1'b1);
            advance();
        end
        check("rand_progress", delivered >= d0 + 6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
